// File: rtl/spi_slave_tx_ctrl.sv
// SPI slave transmit sequencer: arbitrates register readback vs memory burst, inserts dummy
// cycles and chains words into the shifter. Define SPI_TX_CTRL_BYTE_SWAP_EN to byte-reverse memory words.
module spi_slave_tx_ctrl #(
    parameter int DUMMY_W = 8,
    parameter int WORDS_W = 8
) (
    input  logic               sclk,
    input  logic               rstn,
    input  logic               abort_i,
    input  logic               reg_req_i,
    input  logic [31:0]        reg_data_i,
    input  logic [7:0]         reg_len_i,
    input  logic               mem_req_i,
    input  logic [WORDS_W-1:0] mem_words_i,
    input  logic [DUMMY_W-1:0] dummy_i,
    input  logic [31:0]        mem_data_i,
    input  logic               mem_valid_i,
    output logic               mem_ready_o,
    output logic [7:0]         tx_counter_o,
    output logic               tx_counter_upd_o,
    output logic [31:0]        tx_data_o,
    output logic               tx_data_valid_o,
    input  logic               tx_done_i,
    output logic               busy_o,
    output logic               underrun_o
);

    typedef enum logic [2:0] {IDLE, DUMMY, FIRST, SHIFT, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               src_mem_q, src_mem_d;
    logic [7:0]         len_q, len_d;
    logic [WORDS_W-1:0] words_q, words_d;
    logic [DUMMY_W-1:0] dcnt_q, dcnt_d;
    logic               underrun_q, underrun_d;
    logic               load;

    function automatic logic [31:0] mem_word(input logic [31:0] w);
`ifdef SPI_TX_CTRL_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            src_mem_q  <= 1'b0;
            len_q      <= '0;
            words_q    <= '0;
            dcnt_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_mem_q  <= src_mem_d;
            len_q      <= len_d;
            words_q    <= words_d;
            dcnt_q     <= dcnt_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        src_mem_d        = src_mem_q;
        len_d            = len_q;
        words_d          = words_q;
        dcnt_d           = dcnt_q;
        underrun_d       = underrun_q;
        load             = 1'b0;
        mem_ready_o      = 1'b0;
        tx_counter_o     = '0;
        tx_counter_upd_o = 1'b0;
        tx_data_o        = '0;
        tx_data_valid_o  = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (reg_req_i || mem_req_i) begin
                    src_mem_d  = !reg_req_i;
                    len_d      = reg_len_i;
                    words_d    = reg_req_i ? '0 : mem_words_i;
                    // dcnt holds remaining DUMMY cycles minus one
                    dcnt_d     = dummy_i - DUMMY_W'(1);
                    underrun_d = 1'b0;
                    state_d    = (dummy_i != '0) ? DUMMY : FIRST;
                end
                DUMMY: begin
                    if (dcnt_q == '0) state_d = FIRST;
                    else              dcnt_d  = dcnt_q - DUMMY_W'(1);
                end
                FIRST: begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
                SHIFT: if (tx_done_i) begin
                    if (words_q != '0) begin
                        load    = 1'b1;
                        words_d = words_q - WORDS_W'(1);
                    end else begin
                        state_d = DRAIN;
                    end
                end
                DRAIN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            tx_counter_upd_o = 1'b1;
            tx_data_valid_o  = 1'b1;
            if (src_mem_q) begin
                tx_counter_o = 8'd31;
                if (mem_valid_i) begin
                    tx_data_o   = mem_word(mem_data_i);
                    mem_ready_o = 1'b1;
                end else begin
                    underrun_d = 1'b1;  // pad word stays 0
                end
            end else begin
                tx_counter_o = len_q;
                tx_data_o    = reg_data_i;
            end
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign underrun_o = underrun_q;

endmodule
